// File: rtl/router_sync_n.sv
// router_sync_n: N-output synchroniser between the router FSM and its output
// FIFOs. It latches the packet destination, decodes it into one-hot FIFO write
// enables, returns the addressed FIFO's full flag, drives per-port valids from
// the FIFO empty flags, and fires a one-cycle soft reset on any port whose data
// sits unread for TIMEOUT consecutive cycles. Destinations at or beyond
// NUM_PORTS are flagged and never write or stall, so such packets get dropped.
module router_sync_n #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic                 write_enb_reg,
  input  logic [ADDR_W-1:0]    datain,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);

  // One extra bit so that NUM_PORTS == 2**ADDR_W still fits in the compare.
  localparam logic [ADDR_W:0]  PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt [NUM_PORTS];

  // Capture the destination on the FSM strobe and flag it if no such port exists.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q   <= '0;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      addr_q   <= datain;
      addr_err <= ({1'b0, datain} >= PORT_LIMIT);
    end
  end

  // Decode the latched destination into a write enable and pick its full flag.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!addr_err && (addr_q == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  // Per-port watchdog: count unread-valid cycles and pulse soft_reset on expiry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt[i] <= '0;
      end
      soft_reset <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!vld_out[i] || read_enb[i]) begin
          cnt[i]        <= '0;
          soft_reset[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]        <= '0;
          soft_reset[i] <= 1'b1;
        end else begin
          cnt[i]        <= cnt[i] + CNT_W'(1);
          soft_reset[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised N-output synchroniser for the router. It latches the destination address of each packet and decodes it into one-hot FIFO write enables. It muxes the addressed FIFO's full flag back to the router FSM and drives per-port valid outputs from the FIFO empty flags. It runs an independent timeout counter per output port and pulses a soft reset when a port holds data that nobody reads. Successor to the fixed 1x3 sync: port count, address width and timeout are parameters, and invalid addresses are detected and flagged.

Parameters:
NUM_PORTS, 3, number of output FIFOs/ports; legal 2..8
ADDR_W, 2, width of address field on datain; must satisfy 2**ADDR_W >= NUM_PORTS
TIMEOUT, 30, consecutive unread-valid cycles before soft reset; legal 1..255
CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
detect_add  input  1  FSM strobe: address present on datain this cycle
write_enb_reg  input  1  FSM: current cycle writes a byte to the addressed FIFO
datain  input  ADDR_W  destination address (packet header low bits)
read_enb  input  NUM_PORTS  per-port read enable from destination
empty  input  NUM_PORTS  per-FIFO empty flag
full  input  NUM_PORTS  per-FIFO full flag
vld_out  output  NUM_PORTS  per-port data-valid to destination
write_enb  output  NUM_PORTS  one-hot FIFO write enable
fifo_full  output  1  full flag of the addressed FIFO
soft_reset  output  NUM_PORTS  per-FIFO soft reset pulse, registered
addr_err  output  1  latched address is >= NUM_PORTS, registered

Behaviour:
- Reset (resetn low, asynchronous): addr_q=0, addr_err=0, all counters=0, soft_reset=0. Combinational outputs follow the reset state.
- Address latch: at a rising edge with detect_add=1, addr_q<=datain and addr_err<=(datain >= NUM_PORTS).
  - detect_add=0 holds both values.
  - The new address takes effect the cycle after the strobe; same-cycle decode uses the old addr_q.
- write_enb (combinational): one-hot(addr_q) when write_enb_reg=1 and addr_err=0; otherwise all zero. At most one bit is ever high.
- fifo_full (combinational): full[addr_q] when addr_err=0; 0 when addr_err=1. A packet to an invalid address is drained by the FSM and dropped, never stalled.
- vld_out[i] = ~empty[i] (combinational, independent of address).
- Timeout, per port i, evaluated at each rising edge:
  - vld_out[i]=0 or read_enb[i]=1: cnt[i]<=0, soft_reset[i]<=0.
  - Else, if cnt[i]==TIMEOUT-1: soft_reset[i]<=1, cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1, soft_reset[i]<=0.
  - Net effect: soft_reset[i] goes high after exactly TIMEOUT consecutive edges sampling vld=1 and read=0, and stays high for exactly one cycle.
  - If data is still unread afterwards, it re-pulses every TIMEOUT cycles.
- A single cycle with read_enb[i]=1 restarts the count. read_enb while vld_out=0 has no effect beyond clearing.
- Ports are fully independent. Several soft_reset bits may pulse in the same cycle.
- Asserting resetn mid-count clears everything immediately. Counting restarts from 0 after release.
- No latency other than those stated: address 1 cycle, soft_reset registered, all else combinational.

Test Plan:
- Reset, NUM_PORTS=3: drive resetn=0 with empty=3'b111 -> write_enb=0, soft_reset=0, addr_err=0, vld_out=0, fifo_full=0.
- detect_add with datain=0,1,2 in turn, then write_enb_reg=1 -> write_enb=001, 010, 100 from the cycle after each strobe. full=3'b010 with addr 1 -> fifo_full=1; with addr 2 -> fifo_full=0.
- datain=3 with detect_add, then write_enb_reg=1, full=3'b111 -> addr_err=1, write_enb=000, fifo_full=0. Next detect_add with datain=1 -> addr_err=0, write_enb=010.
- empty=3'b110, read_enb=0 for 40 cycles, TIMEOUT=30 -> soft_reset=001 for one cycle only, after the 30th edge. Second pulse after edge 60 if still unread. soft_reset[2:1] stay 0.
- Same as above, but read_enb[0]=1 for one cycle at edge 20 -> no pulse until 30 edges after that read.
- Port 0 counting at cycle 15, pulse resetn low asynchronously between edges -> soft_reset and count clear at once. After release, the pulse comes 30 edges later.
- NUM_PORTS=5, ADDR_W=3, TIMEOUT=4: datain=4 -> write_enb=10000; datain=5 -> addr_err=1. Unread port 3 -> soft_reset[3] pulses every 4 cycles.
